alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 4-bit combinational ALU.
- Widens the datapath and extends the op set with shifts, unsigned compare and an iterative multiply.
- Adds valid/ready handshakes on both input and output, so it drops into the NPC execute stage behind a pipeline register and can stall for multi-cycle ops.
- One operation in flight at a time.

Parameters:
- DWIDTH, 8, operand/result width; power of 2, minimum 4.
- SHW, $clog2(DWIDTH), shift-amount width; derived, not to be overridden.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept this cycle.
- a  in  DWIDTH  operand A.
- b  in  DWIDTH  operand B (shift amount = b[SHW-1:0]).
- fun_sel  in  4  operation select.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  DWIDTH  registered result.
- carry  out  1  registered carry flag.
- overflow  out  1  registered signed-overflow flag.
- zero  out  1  registered, equals (result == 0).
- comp_o  out  1  registered compare outcome.

Behaviour:
- Reset: clk and rst as named above; one clock; synchronous active-high. State -> IDLE; out_valid, result, carry, overflow, zero, comp_o all 0; in_ready=1 the cycle after reset. rst wins over every other input, including mid-multiply: the op is discarded and no output is produced.
- Handshake: transfer occurs on an edge where valid && ready. in_ready = (state==IDLE) || (state==DONE && out_ready). Outputs hold stable while out_valid && !out_ready.
- States:
  - IDLE: accept -> DONE, or -> BUSY for MUL.
  - BUSY: iterate; on the last iteration -> DONE.
  - DONE: on out_ready, accept a new op (-> DONE/BUSY) or go -> IDLE.
- Latency: single-cycle ops give out_valid the cycle after the accepting edge. MUL gives out_valid after the accepting edge + DWIDTH further edges, i.e. DWIDTH cycles later than a single-cycle op. Back-to-back issue is allowed in DONE when out_ready=1.
- Default flags: carry, overflow and comp_o are 0 unless an op below says otherwise.
- fun_sel encoding:
  - 0000 ADD: {carry,result} = a+b. overflow = (a[MSB]==b[MSB]) && (result[MSB]!=a[MSB]).
  - 0001 SUB: {carry,result} = a + ~b + 1; carry=1 means no borrow. overflow = (a[MSB]!=b[MSB]) && (result[MSB]!=a[MSB]). This is true two's-complement overflow; b = min-negative is not special-cased.
  - 0010 NOT: result = ~a.
  - 0011 AND, 0100 OR, 0101 XOR: bitwise.
  - 0110 SLT: comp_o = signed(a) < signed(b), computed as sub-sign XOR sub-overflow. result = {0..., comp_o}.
  - 0111 EQ: comp_o = (a==b). result = a-b.
  - 1000 SLL, 1001 SRL, 1010 SRA: shift by b[SHW-1:0]; SRA sign-fills.
  - 1011 MUL: shift-add over DWIDTH cycles, one multiplier bit per BUSY cycle, 2*DWIDTH accumulator. result = low DWIDTH bits of the product. carry = 1 iff the high DWIDTH bits are non-zero.
  - 1100 SLTU: comp_o = unsigned(a) < unsigned(b). result = {0..., comp_o}.
  - 1101-1111: result 0, all flags 0 except zero=1; completes in a single cycle.
- Boundaries:
  - in_valid while BUSY: ignored, since in_ready=0.
  - Shift amount 0: result = a.
  - MUL with either operand 0: still takes DWIDTH cycles; result 0, zero=1.

Decomposition:
- alu_pkg: fun_sel opcode localparams, state encoding (IDLE/BUSY/DONE), helper constant for MSB index.
- Sub-module alu_mul_iter: start/busy/done, DWIDTH-bit multiplicand/multiplier regs, 2*DWIDTH accumulator, down-counter. Instantiated once.
- Single-cycle ops and flag logic stay in the top module.

Test Plan:
- ADD a=8'h7F b=8'h01 -> result 8'h80, overflow 1, carry 0, zero 0, out_valid 1 cycle after accept.
- SUB a=8'h00 b=8'h80 -> result 8'h80, overflow 1, carry 0. Then SUB a=8'h05 b=8'h05 -> result 0, zero 1, carry 1, overflow 0.
- SLT a=8'hFF b=8'h01 -> comp_o 1, result 8'h01. SLTU with the same operands -> comp_o 0, result 0. SRA a=8'h90 b=2 -> result 8'hE4.
- MUL a=8'h10 b=8'h11 -> result 8'h10, carry 1. in_ready 0 throughout BUSY; out_valid exactly 8 cycles later than an ADD issued the same way.
- Backpressure: hold out_ready=0 for 3 cycles after an ADD -> result and flags stable, in_ready 0. Then out_ready=1 with in_valid=1 (XOR 8'hF0^8'h0F) -> same-edge accept, next cycle result 8'hFF.
- rst asserted on BUSY cycle 4 of a MUL -> next cycle out_valid 0, in_ready 1, all outputs 0. A following ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
//------------------------------------------------------------------------------
// Module : alu_pkg
// Brief  : Opcodes, FSM state encoding and width helpers for alu_seq.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_NOT  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_EQ   = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;
  localparam logic [3:0] OP_SLTU = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int msb_idx(input int width);
    return width - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_mul_iter.sv
//------------------------------------------------------------------------------
// Module : alu_mul_iter
// Brief  : Iterative shift-add multiplier, one multiplier bit per cycle.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_mul_iter #(
  parameter int DWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [DWIDTH-1:0]     a_i,
  input  logic [DWIDTH-1:0]     b_i,
  output logic                  done_o,
  output logic [2*DWIDTH-1:0]   prod_o
);

  localparam int CW = $clog2(DWIDTH);

  logic [DWIDTH-1:0]   mcand_q;
  logic [DWIDTH-1:0]   mplier_q;
  logic [2*DWIDTH-1:0] acc_q;
  logic [2*DWIDTH-1:0] acc_d;
  logic [CW-1:0]       cnt_q;
  logic                busy_q;
  logic [DWIDTH:0]     sum_d;

  // Add into the upper half, then shift the whole accumulator right with the carry.
  assign sum_d  = {1'b0, acc_q[2*DWIDTH-1:DWIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  assign acc_d  = {sum_d, acc_q[DWIDTH-1:1]};
  assign done_o = busy_q && (cnt_q == '0);
  assign prod_o = acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= CW'(DWIDTH - 1);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - 1'b1;
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
//------------------------------------------------------------------------------
// Module : alu_seq
// Brief  : Registered ALU with valid/ready handshakes and iterative multiply.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int SHW    = $clog2(DWIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  input  logic [3:0]        fun_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] result,
  output logic              carry,
  output logic              overflow,
  output logic              zero,
  output logic              comp_o
);

  localparam int MSB = msb_idx(DWIDTH);

  state_e              state_q;
  logic                out_valid_q;
  logic [DWIDTH-1:0]   result_q;
  logic                carry_q;
  logic                overflow_q;
  logic                zero_q;
  logic                comp_q;

  logic [DWIDTH:0]     add_d;
  logic [DWIDTH:0]     sub_d;
  logic                add_ovf;
  logic                sub_ovf;
  logic [SHW-1:0]      shamt;
  logic [DWIDTH-1:0]   res_d;
  logic                c_d;
  logic                v_d;
  logic                cmp_d;
  logic                accept;
  logic                mul_start;
  logic                mul_done;
  logic [2*DWIDTH-1:0] mul_prod;

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (fun_sel == OP_MUL);

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign comp_o    = comp_q;

  assign add_d   = {1'b0, a} + {1'b0, b};
  assign sub_d   = {1'b0, a} + {1'b0, ~b} + {{DWIDTH{1'b0}}, 1'b1};
  assign add_ovf = (a[MSB] == b[MSB]) && (add_d[MSB] != a[MSB]);
  assign sub_ovf = (a[MSB] != b[MSB]) && (sub_d[MSB] != a[MSB]);
  assign shamt   = b[SHW-1:0];

  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    cmp_d = 1'b0;
    case (fun_sel)
      OP_ADD:  begin res_d = add_d[DWIDTH-1:0]; c_d = add_d[DWIDTH]; v_d = add_ovf; end
      OP_SUB:  begin res_d = sub_d[DWIDTH-1:0]; c_d = sub_d[DWIDTH]; v_d = sub_ovf; end
      OP_NOT:  res_d = ~a;
      OP_AND:  res_d = a & b;
      OP_OR:   res_d = a | b;
      OP_XOR:  res_d = a ^ b;
      OP_SLT:  begin cmp_d = sub_d[MSB] ^ sub_ovf; res_d[0] = cmp_d; end
      OP_EQ:   begin cmp_d = (a == b); res_d = sub_d[DWIDTH-1:0]; end
      OP_SLL:  res_d = a << shamt;
      OP_SRL:  res_d = a >> shamt;
      OP_SRA:  res_d = DWIDTH'($signed(a) >>> shamt);
      OP_SLTU: begin cmp_d = (a < b); res_d[0] = cmp_d; end
      default: res_d = '0;
    endcase
  end

  alu_mul_iter #(
    .DWIDTH (DWIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (mul_start),
    .a_i     (a),
    .b_i     (b),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      comp_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (fun_sel == OP_MUL) begin
              state_q     <= ST_BUSY;
              out_valid_q <= 1'b0;
            end else begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              result_q    <= res_d;
              carry_q     <= c_d;
              overflow_q  <= v_d;
              zero_q      <= (res_d == '0);
              comp_q      <= cmp_d;
            end
          end else if ((state_q == ST_DONE) && out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        ST_BUSY: begin
          // Capture the final accumulator value on the last iteration edge.
          if (mul_done) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            result_q    <= mul_prod[DWIDTH-1:0];
            carry_q     <= |mul_prod[2*DWIDTH-1:DWIDTH];
            overflow_q  <= 1'b0;
            zero_q      <= (mul_prod[DWIDTH-1:0] == '0);
            comp_q      <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
//------------------------------------------------------------------------------
// Module : tb_alu_seq
// Brief  : Directed self-checking bench for alu_seq (DWIDTH = 8).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_seq;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       in_valid  = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] a         = 8'h00;
  logic [7:0] b         = 8'h00;
  logic [3:0] fun_sel   = 4'h0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] result;
  logic       carry;
  logic       overflow;
  logic       zero;
  logic       comp_o;

  int n_chk  = 0;
  int n_pass = 0;
  int lat_add;
  int lat_mul;
  int lat;
  bit seen;

  always #5 clk = ~clk;

  alu_seq #(.DWIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .fun_sel   (fun_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .comp_o    (comp_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send(input logic [3:0] f, input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    fun_sel  = f;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int l);
    l = 1;
    while (!out_valid && l < 40) begin
      chk("busy_in_ready", in_ready, 0);
      @(posedge clk); #1;
      l++;
    end
    if (!out_valid) chk("out_timeout", out_valid, 1);
  endtask

  task automatic expect_out(input string tag, input logic [7:0] r, input logic c,
                            input logic v, input logic z, input logic cmp);
    chk({tag, "_result"}, result, r);
    chk({tag, "_carry"}, carry, c);
    chk({tag, "_ovf"}, overflow, v);
    chk({tag, "_zero"}, zero, z);
    chk({tag, "_comp"}, comp_o, cmp);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    expect_out("rst", 8'h00, 0, 0, 0, 0);

    send(4'b0000, 8'h7F, 8'h01);
    wait_out(lat_add);
    chk("add_latency", lat_add, 1);
    expect_out("add", 8'h80, 0, 1, 0, 0);

    send(4'b0001, 8'h00, 8'h80);
    wait_out(lat);
    expect_out("sub_ovf", 8'h80, 0, 1, 0, 0);

    send(4'b0001, 8'h05, 8'h05);
    wait_out(lat);
    expect_out("sub_eq", 8'h00, 1, 0, 1, 0);

    send(4'b0110, 8'hFF, 8'h01);
    wait_out(lat);
    expect_out("slt", 8'h01, 0, 0, 0, 1);

    send(4'b1100, 8'hFF, 8'h01);
    wait_out(lat);
    expect_out("sltu", 8'h00, 0, 0, 1, 0);

    send(4'b1010, 8'h90, 8'h02);
    wait_out(lat);
    expect_out("sra", 8'hE4, 0, 0, 0, 0);

    send(4'b1000, 8'hA5, 8'h00);
    wait_out(lat);
    expect_out("sll0", 8'hA5, 0, 0, 0, 0);

    send(4'b0111, 8'h03, 8'h03);
    wait_out(lat);
    expect_out("eq", 8'h00, 0, 0, 1, 1);

    send(4'b1110, 8'hFF, 8'hFF);
    wait_out(lat);
    expect_out("unused_op", 8'h00, 0, 0, 1, 0);

    // MUL with a competing request held on the input throughout BUSY
    send(4'b1011, 8'h10, 8'h11);
    fun_sel  = 4'b0000;
    a        = 8'h01;
    b        = 8'h01;
    in_valid = 1'b1;
    wait_out(lat_mul);
    in_valid = 1'b0;
    expect_out("mul", 8'h10, 1, 0, 0, 0);
    chk("mul_extra_latency", lat_mul - lat_add, 8);
    @(posedge clk); #1;
    chk("mul_then_idle", out_valid, 0);

    send(4'b1011, 8'h00, 8'h5A);
    wait_out(lat);
    chk("mul0_latency", lat, 9);
    expect_out("mul0", 8'h00, 0, 0, 1, 0);

    @(posedge clk); #1;
    out_ready = 1'b0;
    send(4'b0000, 8'h12, 8'h34);
    wait_out(lat);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      expect_out("bp_hold", 8'h46, 0, 0, 0, 0);
    end
    out_ready = 1'b1;
    fun_sel   = 4'b0101;
    a         = 8'hF0;
    b         = 8'h0F;
    in_valid  = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("xor_valid", out_valid, 1);
    expect_out("xor", 8'hFF, 0, 0, 0, 0);

    @(posedge clk); #1;
    send(4'b1011, 8'hFF, 8'hFF);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    expect_out("midrst", 8'h00, 0, 0, 0, 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_output", seen, 0);

    send(4'b0000, 8'h01, 8'h02);
    wait_out(lat);
    chk("post_rst_latency", lat, 1);
    expect_out("post_rst_add", 8'h03, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
